// File: rtl/fcl_ctrl_pkg.sv
// fcl_ctrl_pkg: shared FSM state type, default layer sizes and index-width helper
package fcl_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
   localparam int NUM_IN_DEF  = 16;
   localparam int NUM_OUT_DEF = 16;
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/fcl_mem_ctrl_if.sv
// fcl_mem_ctrl_if: control, loader, RAM and MAC signals of the weight memory controller
interface fcl_mem_ctrl_if #(
   parameter int RAM_ADDRW = 8,
   parameter int RAM_WIDTH = 32
);
   logic                 load_start_i;
   logic                 run_start_i;
   logic                 abort_i;
   logic                 load_valid_i;
   logic [RAM_WIDTH-1:0] load_data_i;
   logic                 load_ready_o;
   logic                 ram_wren_o;
   logic [RAM_ADDRW-1:0] ram_wr_addr_o;
   logic [RAM_WIDTH-1:0] ram_wr_data_o;
   logic [RAM_ADDRW-1:0] ram_rd_addr_o;
   logic [RAM_WIDTH-1:0] ram_rd_data_i;
   logic                 mac_valid_o;
   logic [RAM_WIDTH-1:0] mac_data_o;
   logic                 mac_first_o;
   logic                 mac_last_o;
   logic                 mac_ready_i;
   logic                 busy_o;
   logic                 done_o;
   logic [15:0]          perf_stall_o;
   modport slave (
      input  load_start_i, run_start_i, abort_i, load_valid_i, load_data_i, ram_rd_data_i, mac_ready_i,
      output load_ready_o, ram_wren_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_addr_o,
             mac_valid_o, mac_data_o, mac_first_o, mac_last_o, busy_o, done_o, perf_stall_o
   );
   modport master (
      output load_start_i, run_start_i, abort_i, load_valid_i, load_data_i, ram_rd_data_i, mac_ready_i,
      input  load_ready_o, ram_wren_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_addr_o,
             mac_valid_o, mac_data_o, mac_first_o, mac_last_o, busy_o, done_o, perf_stall_o
   );
endinterface

// File: rtl/fcl_addr_gen.sv
// fcl_addr_gen: in/out neuron index counters producing the linear weight address
module fcl_addr_gen
   import fcl_ctrl_pkg::*;
#(
   parameter int NUM_IN  = NUM_IN_DEF,
   parameter int NUM_OUT = NUM_OUT_DEF,
   parameter int ADDRW   = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             adv_i,
   output logic [ADDRW-1:0] addr_o,
   output logic             first_o,
   output logic             last_o,
   output logic             final_o
);
   localparam int IW = idx_w(NUM_IN);
   localparam int OW = idx_w(NUM_OUT);
   logic [IW-1:0] in_q, in_d;
   logic [OW-1:0] out_q, out_d;
   assign first_o = in_q == '0;
   assign last_o  = in_q == IW'(NUM_IN - 1);
   assign final_o = last_o && out_q == OW'(NUM_OUT - 1);
   assign addr_o  = ADDRW'(int'(out_q) * NUM_IN + int'(in_q));
   assign in_d  = clr_i ? '0 : adv_i ? (last_o ? '0 : in_q + 1'b1) : in_q;
   assign out_d = clr_i ? '0 : (adv_i && last_o) ? (final_o ? '0 : out_q + 1'b1) : out_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         in_q  <= '0;
         out_q <= '0;
      end else begin
         in_q  <= in_d;
         out_q <= out_d;
      end
   end
endmodule

// File: rtl/fcl_mem_ctrl.sv
// fcl_mem_ctrl: weight RAM loader and zero-latency MAC weight streamer.
// Define FCL_MEM_CTRL_PERF_EN to enable the backpressure stall counter.
module fcl_mem_ctrl
   import fcl_ctrl_pkg::*;
#(
   parameter int RAM_ADDRW = 8,
   parameter int RAM_WIDTH = 32,
   parameter int NUM_IN    = NUM_IN_DEF,
   parameter int NUM_OUT   = NUM_OUT_DEF
) (
   input logic         clk_i,
   input logic         rst_i,
   fcl_mem_ctrl_if.slave ctrl_if
);
   state_e               state_q, state_d;
   logic [RAM_ADDRW-1:0] addr;
   logic                 first, last, fin, wren, mac_valid, hs, clr;
   // abort suppresses both handshakes in its own cycle
   assign wren      = state_q == LOAD && !ctrl_if.abort_i && ctrl_if.load_valid_i;
   assign mac_valid = state_q == RUN && !ctrl_if.abort_i;
   assign hs        = mac_valid && ctrl_if.mac_ready_i;
   assign clr       = ctrl_if.abort_i || (state_q != LOAD && state_q != RUN);
   fcl_addr_gen #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .ADDRW(RAM_ADDRW)) u_addr_gen (
      .clk_i, .rst_i, .clr_i(clr), .adv_i(wren || hs),
      .addr_o(addr), .first_o(first), .last_o(last), .final_o(fin)
   );
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = ctrl_if.load_start_i ? LOAD : ctrl_if.run_start_i ? RUN : IDLE;
         LOAD:    state_d = (ctrl_if.abort_i || (wren && fin)) ? IDLE : LOAD;
         RUN:     state_d = ctrl_if.abort_i ? IDLE : (hs && fin) ? DONE : RUN;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end
   assign ctrl_if.load_ready_o  = state_q == LOAD && !ctrl_if.abort_i;
   assign ctrl_if.ram_wren_o    = wren;
   assign ctrl_if.ram_wr_addr_o = wren ? addr : '0;
   assign ctrl_if.ram_wr_data_o = wren ? ctrl_if.load_data_i : '0;
   assign ctrl_if.ram_rd_addr_o = mac_valid ? addr : '0;
   assign ctrl_if.mac_valid_o   = mac_valid;
   assign ctrl_if.mac_data_o    = mac_valid ? ctrl_if.ram_rd_data_i : '0;
   assign ctrl_if.mac_first_o   = mac_valid && first;
   assign ctrl_if.mac_last_o    = mac_valid && last;
   assign ctrl_if.busy_o        = state_q != IDLE;
   assign ctrl_if.done_o        = state_q == DONE;
`ifdef FCL_MEM_CTRL_PERF_EN
   logic [15:0] stall_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                    stall_q <= '0;
      else if (state_q == IDLE && state_d == RUN)   stall_q <= '0;
      else if (mac_valid && !ctrl_if.mac_ready_i && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
   end
   assign ctrl_if.perf_stall_o = stall_q;
`else
   assign ctrl_if.perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_fcl_mem_ctrl.sv
// tb_fcl_mem_ctrl: randomized load/run scenarios checked against a flat weight-array model
module tb_fcl_mem_ctrl;
   import fcl_ctrl_pkg::*;
   localparam int AW = 8, W = 32, NI = 16, NO = 16, N = NI * NO;
   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;
   fcl_mem_ctrl_if #(.RAM_ADDRW(AW), .RAM_WIDTH(W)) bus ();
   fcl_mem_ctrl #(.RAM_ADDRW(AW), .RAM_WIDTH(W), .NUM_IN(NI), .NUM_OUT(NO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .ctrl_if(bus)
   );
   logic [W-1:0] ram [N];
   logic [W-1:0] exp_mem [N];
   always @(posedge clk_i) if (bus.ram_wren_o) ram[bus.ram_wr_addr_o] <= bus.ram_wr_data_o;
   assign bus.ram_rd_data_i = ram[bus.ram_rd_addr_o];
   int checks = 0, failures = 0;

   task automatic idle_inputs();
      bus.load_start_i = 0; bus.run_start_i = 0; bus.abort_i = 0;
      bus.load_valid_i = 0; bus.load_data_i = '0; bus.mac_ready_i = 0;
   endtask

   task automatic test_reset();
      rst_i = 1;
      idle_inputs();
      @(negedge clk_i); #1;
      checks++;
      if ({bus.busy_o, bus.done_o, bus.load_ready_o, bus.ram_wren_o, bus.mac_valid_o} !== 5'b0) begin
         failures++; $display("FAIL reset_flags got=%b exp=00000", {bus.busy_o, bus.done_o, bus.load_ready_o, bus.ram_wren_o, bus.mac_valid_o});
      end
      checks++;
      if (bus.perf_stall_o !== 16'd0) begin failures++; $display("FAIL reset_perf got=%0d exp=0", bus.perf_stall_o); end
      checks++;
      if ({bus.ram_rd_addr_o, bus.ram_wr_addr_o, bus.mac_data_o, bus.ram_wr_data_o} !== '0) begin
         failures++; $display("FAIL reset_buses got rd=%h wr=%h md=%h wd=%h exp=0", bus.ram_rd_addr_o, bus.ram_wr_addr_o, bus.mac_data_o, bus.ram_wr_data_o);
      end
      @(negedge clk_i);
      rst_i = 0;
   endtask

   task automatic test_load(input bit with_run);
      int cnt = 0, cyc = 0;
      logic [AW-1:0] ea;
      logic [W-1:0] ed;
      @(negedge clk_i);
      bus.load_start_i = 1; bus.run_start_i = 1'(with_run);
      #1 checks++;
      if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL load_idle_busy got=%b exp=0", bus.busy_o); end
      @(negedge clk_i);
      bus.load_start_i = 0; bus.run_start_i = 0;
      while (cnt < N && cyc < 4 * N) begin
         bus.load_valid_i = $urandom_range(0, 3) != 0;
         bus.load_data_i  = $urandom;
         bus.run_start_i  = with_run ? 1'($urandom_range(0, 1)) : 1'b0;
         ea = bus.load_valid_i ? AW'(cnt) : '0;
         ed = bus.load_valid_i ? bus.load_data_i : '0;
         #1 checks++;
         if ({bus.busy_o, bus.load_ready_o, bus.ram_wren_o, bus.ram_wr_addr_o, bus.ram_wr_data_o, bus.mac_valid_o, bus.done_o}
             !== {1'b1, 1'b1, bus.load_valid_i, ea, ed, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL load_beat word=%0d got busy=%b rdy=%b wren=%b addr=%0d data=%h mv=%b done=%b exp wren=%b addr=%0d data=%h",
                     cnt, bus.busy_o, bus.load_ready_o, bus.ram_wren_o, bus.ram_wr_addr_o, bus.ram_wr_data_o, bus.mac_valid_o, bus.done_o,
                     bus.load_valid_i, ea, ed);
         end
         if (bus.load_valid_i) begin exp_mem[cnt] = bus.load_data_i; cnt++; end
         cyc++;
         @(negedge clk_i);
      end
      bus.load_valid_i = 0; bus.run_start_i = 0;
      #1 checks++;
      if (cnt != N || bus.busy_o !== 1'b0 || bus.load_ready_o !== 1'b0) begin
         failures++; $display("FAIL load_end words=%0d busy=%b rdy=%b exp words=%0d busy=0 rdy=0 after %0d cycles", cnt, bus.busy_o, bus.load_ready_o, N, cyc);
      end
   endtask

   task automatic test_run(input int mode, input int abort_at);
      int idx = 0, stalls = 0, cyc = 0, hold = 0;
      bit aborted = 0;
      logic [15:0] exp_perf;
      @(negedge clk_i);
      bus.run_start_i = 1;
      #1 checks++;
      if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL run_idle_busy got=%b exp=0", bus.busy_o); end
      @(negedge clk_i);
      bus.run_start_i = 0;
      while (idx < N && cyc < 8 * N) begin
         bus.mac_ready_i = mode == 0 ? ($urandom_range(0, 3) != 0) : !(idx == 37 && hold < 3);
         if (mode == 1 && idx == 37 && !bus.mac_ready_i) hold++;
         bus.abort_i = idx == abort_at;
         #1 checks++;
         if (bus.abort_i) begin
            if ({bus.mac_valid_o, bus.ram_rd_addr_o, bus.done_o, bus.ram_wren_o} !== '0) begin
               failures++; $display("FAIL abort_cycle got mv=%b addr=%0d done=%b wren=%b exp all 0", bus.mac_valid_o, bus.ram_rd_addr_o, bus.done_o, bus.ram_wren_o);
            end
            @(negedge clk_i);
            bus.abort_i = 0; bus.mac_ready_i = 0;
            #1 checks++;
            if ({bus.busy_o, bus.done_o} !== 2'b00) begin failures++; $display("FAIL abort_idle got busy=%b done=%b exp 0 0", bus.busy_o, bus.done_o); end
            aborted = 1;
            break;
         end
         if ({bus.busy_o, bus.mac_valid_o, bus.ram_rd_addr_o, bus.mac_data_o, bus.mac_first_o, bus.mac_last_o, bus.done_o, bus.ram_wren_o}
             !== {1'b1, 1'b1, AW'(idx), exp_mem[idx], idx % NI == 0, idx % NI == NI - 1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL run_beat idx=%0d got busy=%b mv=%b addr=%0d data=%h first=%b last=%b done=%b wren=%b exp addr=%0d data=%h first=%b last=%b",
                     idx, bus.busy_o, bus.mac_valid_o, bus.ram_rd_addr_o, bus.mac_data_o, bus.mac_first_o, bus.mac_last_o, bus.done_o, bus.ram_wren_o,
                     idx, exp_mem[idx], idx % NI == 0, idx % NI == NI - 1);
         end
         if (bus.mac_ready_i) idx++;
         else stalls++;
         cyc++;
         @(negedge clk_i);
      end
      if (!aborted) begin
`ifdef FCL_MEM_CTRL_PERF_EN
         exp_perf = stalls > 65535 ? 16'hFFFF : 16'(stalls);
`else
         exp_perf = 16'd0;
`endif
         bus.mac_ready_i = 0;
         #1 checks++;
         if (idx != N || {bus.done_o, bus.busy_o, bus.mac_valid_o} !== 3'b110 || bus.perf_stall_o !== exp_perf) begin
            failures++; $display("FAIL run_done beats=%0d done=%b busy=%b mv=%b perf=%0d exp beats=%0d done=1 busy=1 mv=0 perf=%0d",
                                 idx, bus.done_o, bus.busy_o, bus.mac_valid_o, bus.perf_stall_o, N, exp_perf);
         end
         @(negedge clk_i); #1 checks++;
         if ({bus.done_o, bus.busy_o} !== 2'b00) begin failures++; $display("FAIL run_after_done got done=%b busy=%b exp 0 0", bus.done_o, bus.busy_o); end
      end
   endtask

   task automatic test_reset_mid_load();
      int cnt = 0, cyc = 0;
      @(negedge clk_i);
      bus.load_start_i = 1;
      @(negedge clk_i);
      bus.load_start_i = 0;
      while (cnt < 50 && cyc < 1000) begin
         bus.load_valid_i = $urandom_range(0, 1);
         bus.load_data_i  = $urandom;
         if (bus.load_valid_i) begin exp_mem[cnt] = bus.load_data_i; cnt++; end
         cyc++;
         @(negedge clk_i);
      end
      bus.load_valid_i = 1;
      rst_i = 1;
      #1 checks++;
      if ({bus.busy_o, bus.load_ready_o, bus.ram_wren_o, bus.done_o} !== 4'b0 || cnt != 50) begin
         failures++; $display("FAIL reset_mid_load got busy=%b rdy=%b wren=%b done=%b words=%0d exp 0 0 0 0 words=50",
                              bus.busy_o, bus.load_ready_o, bus.ram_wren_o, bus.done_o, cnt);
      end
      @(negedge clk_i);
      rst_i = 0; bus.load_valid_i = 0;
      #1 checks++;
      if ({bus.busy_o, bus.done_o} !== 2'b00) begin failures++; $display("FAIL reset_release got busy=%b done=%b exp 0 0", bus.busy_o, bus.done_o); end
   endtask

   initial begin
      test_reset();
      test_load(0);
      test_run(0, -1);
      test_run(1, -1);
      test_load(1);
      test_run(0, -1);
      test_run(0, 100);
      test_run(1, -1);
      test_reset_mid_load();
      test_run(0, -1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
